seven_seg_mux_counter: RTL and testbench

Parametrised successor to the single-digit hex countdown display. Holds a NUM_DIGITS-digit hexadecimal counter that steps once every TICK_CYCLES clocks, either up or down. The counter supports enable, synchronous load and wrap indication. It drives a multiplexed common-segment display by scanning one digit per SCAN_CYCLES clocks. It sits between the board clock and the segment/anode pins.

---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/hex_to_seven_seg.sv | 33 +++
 rtl/seven_seg_mux_counter.sv | 155 +++++++++++++++
 tb/tb_seven_seg_mux_counter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment definitions for the multiplexed hex display.
// Glyphs are active-high in {A,B,C,D,E,F,G} order (MSB..LSB).
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0 = 7'b1111110;
  localparam seg_t GLYPH_1 = 7'b0110000;
  localparam seg_t GLYPH_2 = 7'b1101101;
  localparam seg_t GLYPH_3 = 7'b1111001;
  localparam seg_t GLYPH_4 = 7'b0110011;
  localparam seg_t GLYPH_5 = 7'b1011011;
  localparam seg_t GLYPH_6 = 7'b1011111;
  localparam seg_t GLYPH_7 = 7'b1110000;
  localparam seg_t GLYPH_8 = 7'b1111111;
  localparam seg_t GLYPH_9 = 7'b1111011;
  localparam seg_t GLYPH_A = 7'b1110111;
  localparam seg_t GLYPH_B = 7'b0011111;
  localparam seg_t GLYPH_C = 7'b1001110;
  localparam seg_t GLYPH_D = 7'b0111101;
  localparam seg_t GLYPH_E = 7'b1001111;
  localparam seg_t GLYPH_F = 7'b1000111;

  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-high seven-segment glyph decoder.
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  // Map each nibble value to its glyph; blank is the fallback
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux_counter.sv
// Multi-digit hex up/down counter with prescaler, load and wrap pulse,
// driving a scanned common-segment display (one digit lit at a time).
module seven_seg_mux_counter
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_CYCLES    = 100_000_000,
  parameter int SCAN_CYCLES    = 100_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [VW-1:0] ALL_ONES   = {VW{1'b1}};

  // Pin levels that mean "nothing lit" for the chosen polarities
  localparam seg_t SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Refuse to elaborate with out-of-range parameters
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gBadDigits
    $error("seven_seg_mux_counter: NUM_DIGITS must be in 1..8");
  end
  if (TICK_CYCLES < 1) begin : gBadTick
    $error("seven_seg_mux_counter: TICK_CYCLES must be >= 1");
  end
  if (SCAN_CYCLES < 1) begin : gBadScan
    $error("seven_seg_mux_counter: SCAN_CYCLES must be >= 1");
  end

  logic [PW-1:0]         presc_q, presc_d;
  logic [VW-1:0]         value_q, value_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  step;
  logic [3:0]            nibble;
  seg_t                  glyph;
  logic [NUM_DIGITS-1:0] one_hot;

  assign step = en && (presc_q == PRESC_LAST);

  // Prescaler and counter next state; load beats a step and suppresses its pulses
  always_comb begin
    presc_d = presc_q;
    value_d = value_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      value_d = load_value;
      presc_d = '0;
    end else if (step) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (up) begin
        value_d = value_q + VW'(1);
        wrap_d  = (value_q == ALL_ONES);
      end else begin
        value_d = value_q - VW'(1);
        wrap_d  = (value_q == '0);
      end
    end else if (en) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Free-running scan timer; the digit index advances at each terminal count
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else begin
      scan_d = scan_q + SW'(1);
    end
  end

  // Select the nibble and one-hot digit enable for the current scan index
  always_comb begin
    nibble  = 4'h0;
    one_hot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble     = value_q[4*i +: 4];
        one_hot[i] = 1'b1;
      end
    end
  end

  hex_to_seven_seg u_decoder (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  // Apply pin polarity ahead of the output registers
  always_comb begin
    seg_d = SEG_ACTIVE_LOW ? ~glyph : glyph;
    an_d  = AN_ACTIVE_LOW ? ~one_hot : one_hot;
  end

  // All state registers, cleared asynchronously to a blank, idle display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      value_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      value_q <= value_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign value = value_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_seven_seg_mux_counter.sv
// Directed bench for seven_seg_mux_counter with a scoreboard of expectations.
`timescale 1ns/1ps
module tb_seven_seg_mux_counter;

  localparam int SEL_VALUE  = 0;
  localparam int SEL_TICK   = 1;
  localparam int SEL_WRAP   = 2;
  localparam int SEL_SEG    = 3;
  localparam int SEL_AN     = 4;
  localparam int SEL_SEGLOW = 5;
  localparam int SEL_VALB   = 6;
  localparam int SEL_TICKB  = 7;
  localparam int SEL_WRAPB  = 8;
  localparam int SEL_ANB    = 9;

  localparam logic [7:0] G_0 = 8'b01111110;
  localparam logic [7:0] G_7 = 8'b01110000;
  localparam logic [7:0] G_A = 8'b01110111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load;
  logic [7:0] loadValue;
  logic [7:0] value, valueB;
  logic       tick, wrap, tickB, wrapB;
  logic [6:0] seg, segLow;
  logic [1:0] an, anB;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } expect_t;

  expect_t sbQ[$];
  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  seven_seg_mux_counter #(
    .NUM_DIGITS(2), .TICK_CYCLES(4), .SCAN_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_value(loadValue), .value(value), .tick(tick), .wrap(wrap),
    .seg(seg), .an(an)
  );

  seven_seg_mux_counter #(
    .NUM_DIGITS(2), .TICK_CYCLES(4), .SCAN_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dutLow (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_value(loadValue), .value(valueB), .tick(tickB), .wrap(wrapB),
    .seg(segLow), .an(anB)
  );

  function automatic logic [7:0] observed(int sel);
    case (sel)
      SEL_VALUE:  return value;
      SEL_TICK:   return {7'b0, tick};
      SEL_WRAP:   return {7'b0, wrap};
      SEL_SEG:    return {1'b0, seg};
      SEL_AN:     return {6'b0, an};
      SEL_SEGLOW: return {1'b0, segLow};
      SEL_VALB:   return valueB;
      SEL_TICKB:  return {7'b0, tickB};
      SEL_WRAPB:  return {7'b0, wrapB};
      SEL_ANB:    return {6'b0, anB};
      default:    return 8'hxx;
    endcase
  endfunction

  task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [7:0] lv);
    en = e;
    up = u;
    load = l;
    loadValue = lv;
  endtask

  task automatic pushExpect(input string tag, input int sel, input logic [7:0] exp);
    expect_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic expectCount(input string tag, input logic [7:0] v, input logic t, input logic w);
    pushExpect({tag, ".value"}, SEL_VALUE, v);
    pushExpect({tag, ".tick"}, SEL_TICK, {7'b0, t});
    pushExpect({tag, ".wrap"}, SEL_WRAP, {7'b0, w});
  endtask

  task automatic checkOutput();
    expect_t e;
    logic [7:0] obs;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      obs = observed(e.sel);
      checkCount++;
      assert (obs === e.exp) passCount++;
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d;
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

    cycles(3);
    expectCount("reset", 8'h00, 1'b0, 1'b0);
    pushExpect("reset.seg", SEL_SEG, 8'h00);
    pushExpect("reset.an", SEL_AN, 8'h03);
    pushExpect("reset.segLow", SEL_SEGLOW, 8'h7F);
    pushExpect("reset.valueB", SEL_VALB, 8'h00);
    pushExpect("reset.tickB", SEL_TICKB, 8'h00);
    pushExpect("reset.wrapB", SEL_WRAPB, 8'h00);
    pushExpect("reset.anB", SEL_ANB, 8'h03);
    checkOutput();

    rst_n = 1'b1;
    cycles(3);
    expectCount("count.pre", 8'h00, 1'b0, 1'b0);
    checkOutput();
    cycles(1);
    expectCount("count.first", 8'h01, 1'b1, 1'b0);
    checkOutput();
    cycles(1);
    expectCount("count.tickEnd", 8'h01, 1'b0, 1'b0);
    checkOutput();
    cycles(15);
    expectCount("count.fifth", 8'h05, 1'b1, 1'b0);
    checkOutput();

    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    cycles(1);
    expectCount("down.load", 8'h00, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    cycles(4);
    expectCount("down.wrap", 8'hFF, 1'b1, 1'b1);
    checkOutput();
    cycles(1);
    expectCount("down.wrapEnd", 8'hFF, 1'b0, 1'b0);
    checkOutput();
    cycles(3);
    expectCount("down.next", 8'hFE, 1'b1, 1'b0);
    checkOutput();

    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE);
    cycles(1);
    expectCount("up.load", 8'hFE, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    cycles(4);
    expectCount("up.ff", 8'hFF, 1'b1, 1'b0);
    checkOutput();
    cycles(4);
    expectCount("up.wrap", 8'h00, 1'b1, 1'b1);
    checkOutput();
    cycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    cycles(10);
    expectCount("freeze", 8'h00, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    cycles(1);
    expectCount("resume.pre", 8'h00, 1'b0, 1'b0);
    checkOutput();
    cycles(1);
    expectCount("resume.step", 8'h01, 1'b1, 1'b0);
    checkOutput();

    cycles(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h3C);
    cycles(1);
    expectCount("collide.load", 8'h3C, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    cycles(3);
    expectCount("collide.pre", 8'h3C, 1'b0, 1'b0);
    checkOutput();
    cycles(1);
    expectCount("collide.step", 8'h3D, 1'b1, 1'b0);
    checkOutput();

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5B);
    cycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    cycles(1);
    expectCount("async.before", 8'h5B, 1'b0, 1'b0);
    checkOutput();
    #3;
    rst_n = 1'b0;
    #1;
    expectCount("async.now", 8'h00, 1'b0, 1'b0);
    pushExpect("async.seg", SEL_SEG, 8'h00);
    pushExpect("async.an", SEL_AN, 8'h03);
    checkOutput();
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    expectCount("async.restartPre", 8'h00, 1'b0, 1'b0);
    checkOutput();
    cycles(1);
    expectCount("async.restart", 8'h01, 1'b1, 1'b0);
    checkOutput();

    rst_n = 1'b0;
    #2;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA7);
    cycles(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycles(1);
      if (k == 1) applyStimulus(1'b0, 1'b1, 1'b0, 8'hA7);
      if (k >= 2) begin
        d = ((k - 1) / 2) % 2;
        pushExpect("scan.value", SEL_VALUE, 8'hA7);
        pushExpect("scan.an", SEL_AN, (d == 1) ? 8'h01 : 8'h02);
        pushExpect("scan.anB", SEL_ANB, (d == 1) ? 8'h01 : 8'h02);
        pushExpect("scan.seg", SEL_SEG, (d == 1) ? G_A : G_7);
        pushExpect("scan.segLow", SEL_SEGLOW, (d == 1) ? (G_A ^ 8'h7F) : (G_7 ^ 8'h7F));
      end else begin
        pushExpect("scan.first.seg", SEL_SEG, G_0);
        pushExpect("scan.first.an", SEL_AN, 8'h02);
      end
      checkOutput();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
